wb_trace_checker: RTL and testbench
===================================

# wb_trace_checker

Self-checking writeback monitor for the 5-stage pipelined register-file processor. It observes the MEM/WB writeback port and compares every architectural register write, in order, against an expected-write stream delivered over a valid/ready handshake by a trace source. It reports match and mismatch counts, the first failing write, and a final done/pass verdict. It sits beside the processor in simulation and on-board debug builds, shares its clock and reset, and never drives the processor.

## Interface
- FIFO_DEPTH, 4, depth of the observed-write buffer (power of 2, 2..16)
- HALT_CYCLES, 8, consecutive cycles of unchanged PCOUT that count as program halt
- TIMEOUT, 1024, maximum cycles in RUN before a forced failing DONE

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wen_out_MEM_WB  in  1  writeback enable from the MEM/WB stage
- waddr_out_MEM_WB  in  4  writeback register address
- wdata_WB  in  16  writeback data
- PCOUT  in  16  current program counter
- exp_valid  in  1  expected-write entry available
- exp_waddr  in  4  expected register address
- exp_wdata  in  16  expected data
- exp_last  in  1  entry is the final expected write
- exp_ready  out  1  checker consumes the entry this cycle
- match_count  out  16  writes that matched
- mismatch_count  out  16  writes that differed in address or data
- first_err_idx  out  16  0-based index of the first mismatching write
- first_err_waddr  out  4  observed address of the first mismatch
- first_err_wdata  out  16  observed data of the first mismatch
- overflow  out  1  sticky; an observed write was dropped
- extra_write  out  1  sticky; a write occurred after DONE
- done  out  1  verdict valid
- pass  out  1  run passed; meaningful only while done=1

## Operation
- Reset values: all counters and first_err_* 0; overflow, extra_write, done, pass, exp_ready 0; FIFO empty; state RUN; halt and timeout counters 0.
- Capture: a cycle with wen_out_MEM_WB=1 and waddr_out_MEM_WB≠0 is a write event. Writes to R0 are ignored. In RUN, each event pushes {waddr, wdata} into the FIFO.
- FIFO full with a push: the event is dropped and overflow is set. A simultaneous pop in the same cycle frees a slot, so that push is accepted and overflow is not set.
- Compare: exp_ready = (state==RUN) && FIFO non-empty. A handshake (exp_valid && exp_ready) pops the head and compares it against exp_waddr/exp_wdata. An exact match increments match_count. Otherwise mismatch_count increments. On the first mismatch only, first_err_idx is set to (match_count+mismatch_count) before the increment, and the head address and data are latched.
- Counters saturate at 16'hFFFF.
- State machine RUN → DONE. The transition is taken on the first of these:
  - handshake with exp_last=1;
  - PCOUT unchanged for HALT_CYCLES consecutive cycles while the FIFO is empty and exp_last has not yet been consumed (missing writes);
  - TIMEOUT cycles elapsed in RUN.
- Entering DONE sets done=1. pass=1 only if the exit was via exp_last, mismatch_count=0 (including the final compare), overflow=0, and the FIFO is empty after the pop. Any other exit gives pass=0.
- DONE: exp_ready=0 and no pushes. Any write event sets extra_write and clears pass; done stays 1. DONE is left only by rst.
- rst asserted at any time, including mid-compare, clears everything immediately. Partial results are not retained.

## Timing
- Write event at edge N → entry visible at FIFO head, and exp_ready can assert, in cycle N+1.
- A handshake in cycle K updates the counters and first_err_* at edge K+1.
- done and pass rise at edge K+1 for an exp_last handshake in cycle K.
- Halt counter: increments on every edge where PCOUT equals its registered previous value, and clears on any change. done rises on the edge where the count reaches HALT_CYCLES.
- Timeout counter: counts RUN edges. done rises on the edge where the count reaches TIMEOUT.
- exp_ready is combinational from state and FIFO occupancy only. It never depends on exp_valid.
- Sustained throughput: one compare per cycle, so a write every cycle never overflows while exp_valid stays high.

## Test plan
- Clean run: writes R1=0x0005, R2=0x000A, R3=0x000F with matching expected entries, last on R3 → match_count=3, mismatch_count=0, done=1, pass=1 one cycle after the third handshake.
- Data mismatch: second write R2=0x000B vs expected 0x000A → mismatch_count=1, first_err_idx=1, first_err_waddr=2, first_err_wdata=0x000B, pass=0 at done.
- Back-pressure: exp_valid low for 6 cycles during 6 back-to-back writes with FIFO_DEPTH=4 → overflow=1 on the 5th write, and pass=0. A repeat with exp_valid low for only 3 cycles → overflow=0 and pass=1.
- Halt with missing writes: 2 of 3 expected writes occur, then PCOUT holds 0x0010 → done=1 and pass=0 exactly 8 edges after PCOUT stops changing; match_count=2.
- R0 and after-DONE writes: a write to R0 mid-run is ignored with no count change. A write to R4 after a passing DONE → extra_write=1, pass drops to 0, done stays 1.
- Mid-run reset: rst pulsed high for 25 ns after 2 matches → all outputs return to 0 asynchronously. The rerun of the 3-write program ends with match_count=3 and pass=1.

Source files
------------

// File: rtl/wb_trace_checker_if.sv
// Writeback observation port and expected-write stream of the trace checker.
// The master side is the processor/trace source, the slave side is the checker.
interface wb_trace_checker_if;
    logic        wen_out_MEM_WB;
    logic [3:0]  waddr_out_MEM_WB;
    logic [15:0] wdata_WB;
    logic [15:0] PCOUT;
    logic        exp_valid;
    logic [3:0]  exp_waddr;
    logic [15:0] exp_wdata;
    logic        exp_last;
    logic        exp_ready;

    modport master (
        output wen_out_MEM_WB, waddr_out_MEM_WB, wdata_WB, PCOUT,
        output exp_valid, exp_waddr, exp_wdata, exp_last,
        input  exp_ready
    );

    modport slave (
        input  wen_out_MEM_WB, waddr_out_MEM_WB, wdata_WB, PCOUT,
        input  exp_valid, exp_waddr, exp_wdata, exp_last,
        output exp_ready
    );
endinterface

// File: rtl/wb_trace_checker.sv
// In-order writeback checker: buffers observed register writes and compares them
// against an expected-write stream, producing counts, first-error capture and a verdict.
module wb_trace_checker #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HALT_CYCLES = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    wb_trace_checker_if.slave bus,
    output logic [15:0]       match_count,
    output logic [15:0]       mismatch_count,
    output logic [15:0]       first_err_idx,
    output logic [3:0]        first_err_waddr,
    output logic [15:0]       first_err_wdata,
    output logic              overflow,
    output logic              extra_write,
    output logic              done,
    output logic              pass
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int HW = $clog2(HALT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [HW-1:0] HALT_MAX = HW'(HALT_CYCLES);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

    typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

    state_t         r_state;
    logic [19:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [15:0]    r_pc_prev;
    logic [HW-1:0]  r_halt_cnt;
    logic [TW-1:0]  r_to_cnt;
    logic [15:0]    r_match_cnt;
    logic [15:0]    r_mismatch_cnt;
    logic [15:0]    r_err_idx;
    logic [3:0]     r_err_waddr;
    logic [15:0]    r_err_wdata;
    logic           r_overflow;
    logic           r_extra;
    logic           r_done;
    logic           r_pass;

    logic           w_event;
    logic           w_empty;
    logic           w_full;
    logic           w_ready;
    logic           w_pop;
    logic           w_push_req;
    logic           w_push;
    logic           w_ovf;
    logic [19:0]    w_head;
    logic           w_match;
    logic           w_last_pass;
    logic [HW-1:0]  w_halt_next;
    logic           w_halt_hit;
    logic [TW-1:0]  w_to_next;
    logic           w_to_hit;

    assign w_event    = bus.wen_out_MEM_WB && (bus.waddr_out_MEM_WB != 4'd0);
    assign w_empty    = (r_count == (AW + 1)'(0));
    assign w_full     = (r_count == FULL_CNT);
    assign w_ready    = (r_state == S_RUN) && !w_empty;
    assign w_pop      = bus.exp_valid && w_ready;
    assign w_push_req = w_event && (r_state == S_RUN);
    // A pop in the same cycle frees the slot the push needs.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf      = w_push_req && w_full && !w_pop;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_match    = (w_head[19:16] == bus.exp_waddr) && (w_head[15:0] == bus.exp_wdata);
    assign w_to_next  = r_to_cnt + TW'(1);
    assign w_to_hit   = (w_to_next == TO_MAX);
    assign w_halt_hit = (w_halt_next == HALT_MAX) && w_empty;
    assign w_last_pass = w_match && (r_mismatch_cnt == 16'd0) && !r_overflow &&
                         (r_count == (AW + 1)'(1)) && !w_push;

    assign bus.exp_ready   = w_ready;
    assign match_count     = r_match_cnt;
    assign mismatch_count  = r_mismatch_cnt;
    assign first_err_idx   = r_err_idx;
    assign first_err_waddr = r_err_waddr;
    assign first_err_wdata = r_err_wdata;
    assign overflow        = r_overflow;
    assign extra_write     = r_extra;
    assign done            = r_done;
    assign pass            = r_pass;

    // Next value of the saturating unchanged-PC counter.
    always_comb begin
        w_halt_next = HW'(0);
        if (bus.PCOUT != r_pc_prev) begin
            w_halt_next = HW'(0);
        end else if (r_halt_cnt == HALT_MAX) begin
            w_halt_next = r_halt_cnt;
        end else begin
            w_halt_next = r_halt_cnt + HW'(1);
        end
    end

    // Observed-write storage; validity is tracked by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.waddr_out_MEM_WB, bus.wdata_WB};
        end
    end

    // FIFO pointers, compare results, halt/timeout tracking and the RUN/DONE verdict FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_RUN;
            r_wr_ptr       <= AW'(0);
            r_rd_ptr       <= AW'(0);
            r_count        <= (AW + 1)'(0);
            r_pc_prev      <= 16'd0;
            r_halt_cnt     <= HW'(0);
            r_to_cnt       <= TW'(0);
            r_match_cnt    <= 16'd0;
            r_mismatch_cnt <= 16'd0;
            r_err_idx      <= 16'd0;
            r_err_waddr    <= 4'd0;
            r_err_wdata    <= 16'd0;
            r_overflow     <= 1'b0;
            r_extra        <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
        end else begin
            r_pc_prev  <= bus.PCOUT;
            r_halt_cnt <= w_halt_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                if (w_match) begin
                    if (r_match_cnt != 16'hFFFF) r_match_cnt <= r_match_cnt + 16'd1;
                end else begin
                    // A zero mismatch count means this is the first failing write.
                    if (r_mismatch_cnt == 16'd0) begin
                        r_err_idx   <= r_match_cnt + r_mismatch_cnt;
                        r_err_waddr <= w_head[19:16];
                        r_err_wdata <= w_head[15:0];
                    end
                    if (r_mismatch_cnt != 16'hFFFF) r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
                end
            end
            case (r_state)
                S_RUN: begin
                    r_to_cnt <= w_to_next;
                    if (w_pop && bus.exp_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= w_last_pass;
                    end else if (w_halt_hit || w_to_hit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (w_event) begin
                        r_extra <= 1'b1;
                        r_pass  <= 1'b0;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: a trace-source process feeds expected writes
// from a queue and checks the DUT counters against a scoreboard of driven writes.
module tb_wb_trace_checker;
    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
        logic        last;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [15:0] match_count;
    logic [15:0] mismatch_count;
    logic [15:0] first_err_idx;
    logic [3:0]  first_err_waddr;
    logic [15:0] first_err_wdata;
    logic        overflow;
    logic        extra_write;
    logic        done;
    logic        pass;

    wb_trace_checker_if intf ();

    wb_trace_checker dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (intf),
        .match_count     (match_count),
        .mismatch_count  (mismatch_count),
        .first_err_idx   (first_err_idx),
        .first_err_waddr (first_err_waddr),
        .first_err_wdata (first_err_wdata),
        .overflow        (overflow),
        .extra_write     (extra_write),
        .done            (done),
        .pass            (pass)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    ent_t exp_q[$];
    ent_t ref_q[$];
    bit   src_en = 1'b0;
    bit   pc_hold = 1'b0;
    bit   exp_pass = 1'b0;
    int   m_match = 0;
    int   m_mismatch = 0;
    int   m_err_idx = 0;
    logic [3:0]  m_err_a = 4'd0;
    logic [15:0] m_err_d = 16'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic ex(input logic [3:0] a, input logic [15:0] d, input bit last);
        ent_t e;
        e.a = a;
        e.d = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Drives one writeback cycle starting at a negedge; returns at the next negedge.
    task automatic wr(input logic [3:0] a, input logic [15:0] d, input bit keep);
        ent_t e;
        intf.wen_out_MEM_WB   = 1'b1;
        intf.waddr_out_MEM_WB = a;
        intf.wdata_WB         = d;
        if (keep && a != 4'd0) begin
            e.a = a;
            e.d = d;
            e.last = 1'b0;
            ref_q.push_back(e);
        end
        @(negedge clk);
        intf.wen_out_MEM_WB = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int i = 0; i < bound && done !== 1'b1; i++) @(negedge clk);
        chk(tag, 16'(done), 16'd1);
    endtask

    task automatic clear_model();
        src_en = 1'b0;
        exp_q.delete();
        ref_q.delete();
        m_match = 0;
        m_mismatch = 0;
        m_err_idx = 0;
        m_err_a = 4'd0;
        m_err_d = 16'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        clear_model();
        #10;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Program counter: advances every cycle unless the program is held at 0x0010.
    initial begin
        intf.PCOUT = 16'd0;
        forever begin
            @(negedge clk);
            #1;
            if (pc_hold) intf.PCOUT = 16'h0010;
            else intf.PCOUT = intf.PCOUT + 16'd1;
        end
    end

    // Trace source and scoreboard: serves exp_q, predicts counters from ref_q.
    initial begin : src
        bit   hs;
        bit   chk_due;
        bit   last_due;
        ent_t e;
        ent_t r;
        intf.exp_valid = 1'b0;
        intf.exp_waddr = 4'd0;
        intf.exp_wdata = 16'd0;
        intf.exp_last  = 1'b0;
        chk_due  = 1'b0;
        last_due = 1'b0;
        e = '0;
        forever begin
            @(negedge clk);
            #1;
            if (chk_due && !rst) begin
                chk("match_count", match_count, 16'(m_match));
                chk("mismatch_count", mismatch_count, 16'(m_mismatch));
                if (m_mismatch != 0) begin
                    chk("first_err_idx", first_err_idx, 16'(m_err_idx));
                    chk("first_err_waddr", 16'(first_err_waddr), 16'(m_err_a));
                    chk("first_err_wdata", first_err_wdata, m_err_d);
                end
            end
            if (last_due && !rst) begin
                chk("done_after_last", 16'(done), 16'd1);
                chk("pass_after_last", 16'(pass), 16'(exp_pass));
            end
            chk_due  = 1'b0;
            last_due = 1'b0;
            if (src_en && !rst && exp_q.size() != 0) begin
                e = exp_q[0];
                intf.exp_valid = 1'b1;
                intf.exp_waddr = e.a;
                intf.exp_wdata = e.d;
                intf.exp_last  = e.last;
            end else begin
                intf.exp_valid = 1'b0;
                intf.exp_last  = 1'b0;
            end
            #1;
            hs = intf.exp_valid && (intf.exp_ready === 1'b1);
            if (hs && e.last) chk("done_before_last", 16'(done), 16'd0);
            @(posedge clk);
            if (hs && !rst) begin
                void'(exp_q.pop_front());
                r = (ref_q.size() != 0) ? ref_q.pop_front() : ent_t'(0);
                if (r.a == e.a && r.d == e.d) begin
                    m_match++;
                end else begin
                    if (m_mismatch == 0) begin
                        m_err_idx = m_match;
                        m_err_a = r.a;
                        m_err_d = r.d;
                    end
                    m_mismatch++;
                end
                chk_due  = 1'b1;
                last_due = e.last;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        intf.wen_out_MEM_WB   = 1'b0;
        intf.waddr_out_MEM_WB = 4'd0;
        intf.wdata_WB         = 16'd0;
        #12;
        chk("rst_match", match_count, 16'd0);
        chk("rst_mismatch", mismatch_count, 16'd0);
        chk("rst_err_idx", first_err_idx, 16'd0);
        chk("rst_err_waddr", 16'(first_err_waddr), 16'd0);
        chk("rst_err_wdata", first_err_wdata, 16'd0);
        chk("rst_overflow", 16'(overflow), 16'd0);
        chk("rst_extra", 16'(extra_write), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_pass", 16'(pass), 16'd0);
        chk("rst_exp_ready", 16'(intf.exp_ready), 16'd0);
        @(negedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);

        // Clean run
        exp_pass = 1'b1;
        ex(4'd1, 16'h0005, 1'b0); ex(4'd2, 16'h000A, 1'b0); ex(4'd3, 16'h000F, 1'b1);
        src_en = 1'b1;
        wr(4'd1, 16'h0005, 1'b1); wr(4'd2, 16'h000A, 1'b1); wr(4'd3, 16'h000F, 1'b1);
        wait_done("clean_done", 20);
        chk("clean_match", match_count, 16'd3);
        chk("clean_mismatch", mismatch_count, 16'd0);
        chk("clean_pass", 16'(pass), 16'd1);

        // Data mismatch on the second write
        do_reset();
        exp_pass = 1'b0;
        ex(4'd1, 16'h0005, 1'b0); ex(4'd2, 16'h000A, 1'b0); ex(4'd3, 16'h000F, 1'b1);
        src_en = 1'b1;
        wr(4'd1, 16'h0005, 1'b1); wr(4'd2, 16'h000B, 1'b1); wr(4'd3, 16'h000F, 1'b1);
        wait_done("mm_done", 20);
        chk("mm_mismatch", mismatch_count, 16'd1);
        chk("mm_err_idx", first_err_idx, 16'd1);
        chk("mm_err_waddr", 16'(first_err_waddr), 16'd2);
        chk("mm_err_wdata", first_err_wdata, 16'h000B);
        chk("mm_pass", 16'(pass), 16'd0);

        // Back-pressure for 6 cycles: writes 5 and 6 are dropped
        do_reset();
        exp_pass = 1'b0;
        for (int i = 0; i < 4; i++) ex(4'(i + 1), 16'h0100 + 16'(i), (i == 3));
        for (int i = 0; i < 6; i++) begin
            wr(4'(i + 1), 16'h0100 + 16'(i), (i < 4));
            chk("bp6_overflow", 16'(overflow), (i >= 4) ? 16'd1 : 16'd0);
        end
        src_en = 1'b1;
        wait_done("bp6_done", 20);
        chk("bp6_match", match_count, 16'd4);
        chk("bp6_pass", 16'(pass), 16'd0);

        // Back-pressure for only 3 cycles: no drop
        do_reset();
        exp_pass = 1'b1;
        for (int i = 0; i < 6; i++) ex(4'(i + 1), 16'h0200 + 16'(i), (i == 5));
        for (int i = 0; i < 6; i++) begin
            if (i == 3) src_en = 1'b1;
            wr(4'(i + 1), 16'h0200 + 16'(i), 1'b1);
            chk("bp3_overflow", 16'(overflow), 16'd0);
        end
        wait_done("bp3_done", 20);
        chk("bp3_match", match_count, 16'd6);
        chk("bp3_pass", 16'(pass), 16'd1);

        // Halt with a missing write
        do_reset();
        exp_pass = 1'b0;
        ex(4'd1, 16'h0001, 1'b0); ex(4'd2, 16'h0002, 1'b0); ex(4'd3, 16'h0003, 1'b1);
        src_en = 1'b1;
        wr(4'd1, 16'h0001, 1'b1); wr(4'd2, 16'h0002, 1'b1);
        idle(4);
        pc_hold = 1'b1;
        @(negedge clk);
        idle(7);
        chk("halt_done_early", 16'(done), 16'd0);
        @(negedge clk);
        chk("halt_done", 16'(done), 16'd1);
        chk("halt_pass", 16'(pass), 16'd0);
        chk("halt_match", match_count, 16'd2);
        pc_hold = 1'b0;

        // R0 write ignored, then a write after a passing DONE
        do_reset();
        exp_pass = 1'b1;
        ex(4'd1, 16'h0011, 1'b0); ex(4'd2, 16'h0022, 1'b1);
        src_en = 1'b1;
        wr(4'd1, 16'h0011, 1'b1); wr(4'd0, 16'h0099, 1'b1); wr(4'd2, 16'h0022, 1'b1);
        wait_done("r0_done", 20);
        chk("r0_match", match_count, 16'd2);
        chk("r0_pass", 16'(pass), 16'd1);
        chk("r0_extra_before", 16'(extra_write), 16'd0);
        wr(4'd4, 16'h0044, 1'b0);
        chk("extra_write", 16'(extra_write), 16'd1);
        chk("extra_pass", 16'(pass), 16'd0);
        chk("extra_done", 16'(done), 16'd1);
        chk("extra_match", match_count, 16'd2);

        // Mid-run reset after two matches, then a full rerun
        do_reset();
        exp_pass = 1'b1;
        ex(4'd1, 16'h0005, 1'b0); ex(4'd2, 16'h000A, 1'b0); ex(4'd3, 16'h000F, 1'b1);
        src_en = 1'b1;
        wr(4'd1, 16'h0005, 1'b1); wr(4'd2, 16'h000A, 1'b1);
        idle(4);
        chk("mid_match_pre", match_count, 16'd2);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_match", match_count, 16'd0);
        chk("mid_rst_mismatch", mismatch_count, 16'd0);
        chk("mid_rst_done", 16'(done), 16'd0);
        chk("mid_rst_pass", 16'(pass), 16'd0);
        chk("mid_rst_exp_ready", 16'(intf.exp_ready), 16'd0);
        clear_model();
        #24;
        rst = 1'b0;
        @(negedge clk);
        exp_pass = 1'b1;
        ex(4'd1, 16'h0005, 1'b0); ex(4'd2, 16'h000A, 1'b0); ex(4'd3, 16'h000F, 1'b1);
        src_en = 1'b1;
        wr(4'd1, 16'h0005, 1'b1); wr(4'd2, 16'h000A, 1'b1); wr(4'd3, 16'h000F, 1'b1);
        wait_done("rerun_done", 20);
        chk("rerun_match", match_count, 16'd3);
        chk("rerun_pass", 16'(pass), 16'd1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
